morse_stream_decoder: RTL and testbench

//  Parametrised successor to the fixed 10-letter morse FSM. Samples one 2-bit morse symbol per

---
 rtl/morse_stream_decoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_morse_stream_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_stream_decoder.sv
// Morse symbol stream to ASCII decoder with a fall-through output FIFO.
// One 2-bit symbol is sampled per clock. Letters are decoded on letter-end. Word gaps insert a space.
module morse_stream_decoder #(
    parameter int MAX_SYMS    = 5,
    parameter int DEPTH       = 10,
    parameter int WORD_GAP_EN = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   inputSignal,
    output logic [7:0]                   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done,
    output logic                         overflow,
    output logic                         busy
);

    localparam int unsigned LEN_W = $clog2(MAX_SYMS + 2);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    logic [1:0]          r_state;
    logic [LEN_W-1:0]    r_len;
    logic [MAX_SYMS-1:0] r_pattern;
    logic [7:0]          r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_out_data;
    logic                r_valid;
    logic                r_full;
    logic                r_ovf;
    logic                r_busy;
    logic                r_any_pushed;
    logic                r_last_space;

    logic [1:0]          w_state_next;
    logic [LEN_W-1:0]    w_len_next;
    logic [MAX_SYMS-1:0] w_pat_next;
    logic                w_push_req;
    logic [7:0]          w_push_char;
    logic                w_is_sym;
    logic                w_is_end;
    logic                w_dash;
    logic [7:0]          w_lookup;
    logic                w_do_push;
    logic                w_do_pop;
    logic                w_drop;
    logic [CNT_W-1:0]    w_count_next;
    logic [PTR_W-1:0]    w_rd_next;
    logic [7:0]          w_head_next;

    // Key is the letter length plus its symbols, first symbol in the highest used bit (dot=0, dash=1).
    function automatic logic [7:0] f_lookup(input logic [2:0] len, input logic [4:0] code);
        logic [7:0] ch;
        ch = 8'h3F;
        case (len)
            3'd1: ch = code[0] ? 8'h54 : 8'h45;
            3'd2: begin
                case (code[1:0])
                    2'b00:   ch = 8'h49;
                    2'b01:   ch = 8'h41;
                    2'b10:   ch = 8'h4E;
                    default: ch = 8'h4D;
                endcase
            end
            3'd3: begin
                case (code[2:0])
                    3'b000:  ch = 8'h53;
                    3'b001:  ch = 8'h55;
                    3'b010:  ch = 8'h52;
                    3'b011:  ch = 8'h57;
                    3'b100:  ch = 8'h44;
                    3'b101:  ch = 8'h4B;
                    3'b110:  ch = 8'h47;
                    default: ch = 8'h4F;
                endcase
            end
            3'd4: begin
                case (code[3:0])
                    4'b0000: ch = 8'h48;
                    4'b0001: ch = 8'h56;
                    4'b0010: ch = 8'h46;
                    4'b0100: ch = 8'h4C;
                    4'b0110: ch = 8'h50;
                    4'b0111: ch = 8'h4A;
                    4'b1000: ch = 8'h42;
                    4'b1001: ch = 8'h58;
                    4'b1010: ch = 8'h43;
                    4'b1011: ch = 8'h59;
                    4'b1100: ch = 8'h5A;
                    4'b1101: ch = 8'h51;
                    default: ch = 8'h3F;
                endcase
            end
            3'd5: begin
                case (code)
                    5'b11111: ch = 8'h30;
                    5'b01111: ch = 8'h31;
                    5'b00111: ch = 8'h32;
                    5'b00011: ch = 8'h33;
                    5'b00001: ch = 8'h34;
                    5'b00000: ch = 8'h35;
                    5'b10000: ch = 8'h36;
                    5'b11000: ch = 8'h37;
                    5'b11100: ch = 8'h38;
                    5'b11110: ch = 8'h39;
                    default:  ch = 8'h3F;
                endcase
            end
            default: ch = 8'h3F;
        endcase
        return ch;
    endfunction

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_is_sym = (inputSignal == 2'b01) || (inputSignal == 2'b10);
    assign w_is_end = (inputSignal == 2'b11);
    assign w_dash   = (inputSignal == 2'b10);
    assign w_lookup = f_lookup(3'(r_len), 5'(r_pattern));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_pattern <= '0;
        end else begin
            r_state   <= w_state_next;
            r_len     <= w_len_next;
            r_pattern <= w_pat_next;
        end
    end

    // Letter FSM: accumulates symbols and raises a push request on letter end / word gap.
    always_comb begin
        w_state_next = r_state;
        w_len_next   = r_len;
        w_pat_next   = r_pattern;
        w_push_req   = 1'b0;
        w_push_char  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_is_sym) begin
                    w_state_next = S_ACCUM;
                    w_len_next   = LEN_W'(1);
                    w_pat_next   = MAX_SYMS'(w_dash);
                end else if (w_is_end) begin
                    if ((WORD_GAP_EN != 0) && r_any_pushed && !r_last_space) begin
                        w_push_req  = 1'b1;
                        w_push_char = 8'h20;
                    end
                end
            end
            S_ACCUM: begin
                if (w_is_sym) begin
                    if (r_len == LEN_W'(MAX_SYMS)) begin
                        w_state_next = S_ERR;
                        w_len_next   = LEN_W'(MAX_SYMS + 1);
                    end else begin
                        w_len_next = r_len + LEN_W'(1);
                        w_pat_next = MAX_SYMS'({r_pattern, w_dash});
                    end
                end else if (w_is_end) begin
                    w_push_req   = 1'b1;
                    w_push_char  = w_lookup;
                    w_state_next = S_IDLE;
                    w_len_next   = '0;
                end
            end
            S_ERR: begin
                if (w_is_end) begin
                    w_push_req   = 1'b1;
                    w_push_char  = 8'h3F;
                    w_state_next = S_IDLE;
                    w_len_next   = '0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FIFO control; a full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        w_do_pop     = out_ready && r_valid;
        w_do_push    = w_push_req && (!r_full || w_do_pop);
        w_drop       = w_push_req && r_full && !w_do_pop;
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
        w_rd_next = w_do_pop ? f_inc(r_rd_ptr) : r_rd_ptr;
        if (w_do_push && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_do_pop))) begin
            w_head_next = w_push_char;
        end else begin
            w_head_next = r_mem[w_rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_push_char;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_out_data   <= 8'h00;
            r_valid      <= 1'b0;
            r_full       <= 1'b0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_any_pushed <= 1'b0;
            r_last_space <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr     <= f_inc(r_wr_ptr);
                r_any_pushed <= 1'b1;
                r_last_space <= (w_push_char == 8'h20);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            r_full   <= (w_count_next == CNT_W'(DEPTH));
            r_busy   <= (w_state_next != S_IDLE);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_count_next != '0) begin
                r_out_data <= w_head_next;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_valid;
    assign count     = r_count;
    assign done      = r_full;
    assign overflow  = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Bench for morse_stream_decoder: two instances (DEPTH 10 and 3) share one stimulus stream
// and are compared each cycle against a string/queue reference model.
module tb_morse_stream_decoder;

    localparam int MAX_SYMS = 5;
    localparam int GAP_EN   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sig;
    logic       rdy;

    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_done, b_done, a_ovf, b_ovf, a_busy, b_busy;
    logic [3:0] a_count;
    logic [1:0] b_count;

    int n_total = 0;
    int n_bad   = 0;

    morse_stream_decoder #(.MAX_SYMS(MAX_SYMS), .DEPTH(10), .WORD_GAP_EN(GAP_EN)) u_dut_a (
        .clk(clk), .reset(reset), .inputSignal(sig),
        .out_data(a_data), .out_valid(a_valid), .out_ready(rdy),
        .count(a_count), .done(a_done), .overflow(a_ovf), .busy(a_busy)
    );

    morse_stream_decoder #(.MAX_SYMS(MAX_SYMS), .DEPTH(3), .WORD_GAP_EN(GAP_EN)) u_dut_b (
        .clk(clk), .reset(reset), .inputSignal(sig),
        .out_data(b_data), .out_valid(b_valid), .out_ready(rdy),
        .count(b_count), .done(b_done), .overflow(b_ovf), .busy(b_busy)
    );

    always #5 clk = ~clk;

    string mcode [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--..",
                          "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                          "---..", "----."};

    // Reference model state
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int         m_depth [2] = '{10, 3};
    bit         m_any [2];
    bit         m_last_sp [2];
    bit         m_ovf [2];
    string      m_syms;
    bit         m_err;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_lookup(input string s);
        for (int i = 0; i < 36; i++) begin
            if (mcode[i] == s) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
        end
        return 8'h3F;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int k = 0; k < 2; k++) begin
            m_any[k]     = 0;
            m_last_sp[k] = 0;
            m_ovf[k]     = 0;
        end
        m_syms = "";
        m_err  = 0;
    endtask

    task automatic model_fifo(input int k, input bit have_push, input logic [7:0] ch);
        int sz;
        bit pop;
        bit acc;
        sz  = (k == 0) ? qa.size() : qb.size();
        pop = rdy && (sz > 0);
        acc = have_push && ((sz < m_depth[k]) || pop);
        if (have_push && !acc) m_ovf[k] = 1;
        if (k == 0) begin
            if (pop) void'(qa.pop_front());
            if (acc) qa.push_back(ch);
        end else begin
            if (pop) void'(qb.pop_front());
            if (acc) qb.push_back(ch);
        end
        if (acc) begin
            m_any[k]     = 1;
            m_last_sp[k] = (ch == 8'h20);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit         lp;
        bit         gap;
        logic [7:0] lc;
        lp  = 0;
        gap = 0;
        lc  = 8'h00;
        if (sig == 2'b01 || sig == 2'b10) begin
            if (!m_err) begin
                if (m_syms.len() == MAX_SYMS) m_err = 1;
                else if (sig == 2'b10) m_syms = {m_syms, "-"};
                else m_syms = {m_syms, "."};
            end
        end else if (sig == 2'b11) begin
            if (m_err) begin
                lp = 1;
                lc = 8'h3F;
            end else if (m_syms.len() > 0) begin
                lp = 1;
                lc = m_lookup(m_syms);
            end else begin
                gap = 1;
            end
            m_err  = 0;
            m_syms = "";
        end
        for (int k = 0; k < 2; k++) begin
            model_fifo(k, lp || (gap && (GAP_EN != 0) && m_any[k] && !m_last_sp[k]),
                       gap ? 8'h20 : lc);
        end
    endtask

    task automatic check_all();
        int  busy_exp;
        busy_exp = (m_syms.len() > 0 || m_err) ? 1 : 0;
        check_eq("a_valid", int'(a_valid), int'(qa.size() != 0));
        check_eq("a_count", int'(a_count), qa.size());
        check_eq("a_done", int'(a_done), int'(qa.size() == 10));
        check_eq("a_ovf", int'(a_ovf), int'(m_ovf[0]));
        check_eq("a_busy", int'(a_busy), busy_exp);
        if (qa.size() != 0) check_eq("a_data", int'(a_data), int'(qa[0]));
        check_eq("b_valid", int'(b_valid), int'(qb.size() != 0));
        check_eq("b_count", int'(b_count), qb.size());
        check_eq("b_done", int'(b_done), int'(qb.size() == 3));
        check_eq("b_ovf", int'(b_ovf), int'(m_ovf[1]));
        check_eq("b_busy", int'(b_busy), busy_exp);
        if (qb.size() != 0) check_eq("b_data", int'(b_data), int'(qb[0]));
    endtask

    task automatic step(input logic [1:0] s, input logic r);
        sig = s;
        rdy = r;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send_letter(input string code, input logic r);
        for (int i = 0; i < code.len(); i++) begin
            step((code[i] == "-") ? 2'b10 : 2'b01, r);
        end
        step(2'b11, r);
    endtask

    task automatic do_reset();
        sig   = 2'b00;
        rdy   = 1'b0;
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        sig   = 2'b00;
        rdy   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_data", int'(a_data), 0);
        check_eq("rst_valid", int'(a_valid), 0);
        check_eq("rst_count", int'(a_count), 0);
        check_eq("rst_done", int'(a_done), 0);
        check_eq("rst_ovf", int'(a_ovf), 0);
        check_eq("rst_busy", int'(a_busy), 0);
        reset = 1'b0;

        // Single letter 'A'
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        step(2'b11, 1'b0);
        check_eq("t1_data", int'(a_data), 8'h41);
        check_eq("t1_count", int'(a_count), 1);
        check_eq("t1_valid", int'(a_valid), 1);
        check_eq("t1_busy", int'(a_busy), 0);

        // S, T, one space, repeated gap adds nothing
        do_reset();
        step(2'b01, 1'b0); step(2'b01, 1'b0); step(2'b01, 1'b0); step(2'b11, 1'b0);
        step(2'b10, 1'b0); step(2'b11, 1'b0); step(2'b11, 1'b0); step(2'b11, 1'b0);
        check_eq("t2_count", int'(a_count), 3);
        check_eq("t2_s", int'(a_data), 8'h53);
        step(2'b00, 1'b1);
        check_eq("t2_t", int'(a_data), 8'h54);
        step(2'b00, 1'b1);
        check_eq("t2_sp", int'(a_data), 8'h20);
        step(2'b00, 1'b1);
        check_eq("t2_empty", int'(a_count), 0);

        // Too-long letter and digit zero
        do_reset();
        for (int i = 0; i < 6; i++) step(2'b01, 1'b0);
        check_eq("t3_busy_err", int'(a_busy), 1);
        step(2'b11, 1'b0);
        check_eq("t3_err", int'(a_data), 8'h3F);
        step(2'b00, 1'b1);
        for (int i = 0; i < 5; i++) step(2'b10, 1'b0);
        step(2'b11, 1'b0);
        check_eq("t3_zero", int'(a_data), 8'h30);

        // Fill, overflow, then push+pop while full
        do_reset();
        for (int i = 0; i < 11; i++) send_letter(mcode[i], 1'b0);
        check_eq("t4_count", int'(a_count), 10);
        check_eq("t4_done", int'(a_done), 1);
        check_eq("t4_ovf", int'(a_ovf), 1);
        step(2'b10, 1'b0);
        step(2'b11, 1'b1);
        check_eq("t4_cnt_hold", int'(a_count), 10);
        check_eq("t4_head", int'(a_data), 8'h42);
        for (int i = 0; i < 10; i++) step(2'b00, 1'b1);
        check_eq("t4_ovf_sticky", int'(a_ovf), 1);

        // Asynchronous reset mid-letter
        do_reset();
        step(2'b01, 1'b0);
        step(2'b10, 1'b0);
        check_eq("t5_busy_pre", int'(a_busy), 1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("t5_busy", int'(a_busy), 0);
        check_eq("t5_valid", int'(a_valid), 0);
        check_eq("t5_count", int'(a_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        step(2'b11, 1'b0);
        check_eq("t5_nospace", int'(a_count), 0);

        // Continuous push/pop through the DEPTH=3 instance
        do_reset();
        for (int i = 0; i < 20; i++) send_letter(mcode[$urandom_range(0, 35)], 1'b1);

        // Random mix of letters, gaps, long letters and back-pressure
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            int          w;
            logic [1:0]  s;
            w = $urandom_range(0, 9);
            if (w < 4) s = 2'b01;
            else if (w < 7) s = 2'b10;
            else if (w < 9) s = 2'b11;
            else s = 2'b00;
            step(s, ($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 12; c++) step(2'b00, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
